// File: rtl/adder_issuer_pkg.sv
// rtl/adder_issuer_pkg.sv - shared state type, default widths and pointer helper for adder_issuer
package adder_issuer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int A_W_DEF = 4;
  localparam int C_W_DEF = 7;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/adder_issuer_fifo.sv
// rtl/adder_issuer_fifo.sv - in-order result FIFO with registered storage and synchronous clear
module adder_issuer_fifo
  import adder_issuer_pkg::*;
#(
  parameter int W     = C_W_DEF,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);

  localparam int CNTW = PW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CNTW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNTW'(DEPTH));
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/adder_issuer.sv
// rtl/adder_issuer.sv - credit-based issuer feeding an adder and returning results in order
// Optional result checking (err, err_cnt) is enabled by defining ADDER_ISSUER_CHECK_EN.
module adder_issuer
  import adder_issuer_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int C_W     = C_W_DEF,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [A_W-1:0] in_b,
  output logic [A_W-1:0] add_a,
  output logic [A_W-1:0] add_b,
  output logic           add_valid,
  input  logic [C_W-1:0] add_c,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [C_W-1:0] res_c,
  output logic           busy
`ifdef ADDER_ISSUER_CHECK_EN
  ,
  output logic           err,
  output logic [7:0]     err_cnt
`endif
);

  localparam int PW  = ptr_w(DEPTH);
  localparam int CRW = PW + 1;

  state_e             state_q, state_d;
  logic [CRW-1:0]     credits_q, credits_d;
  logic               rdy_en_q;
  logic               issue_q;
  logic [A_W-1:0]     a_q, b_q;
  logic [LATENCY-1:0] pipe_q;
  logic               accept, capture, pop, pipe_busy, clear;
  logic               fifo_full, fifo_empty;
  logic [PW:0]        fifo_count;

  // rdy_en_q keeps in_ready low for the first cycle out of reset.
  assign in_ready  = rdy_en_q && (state_q == RUN) && (credits_q != '0);
  assign accept    = in_valid && in_ready;
  assign capture   = pipe_q[LATENCY-1];
  assign pop       = res_valid && res_ready;
  assign pipe_busy = issue_q || (|pipe_q);
  assign clear     = (state_q == CLEAR);
  assign add_valid = issue_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign res_valid = !fifo_empty;
  assign busy      = pipe_busy || (fifo_count != '0) || (state_q != RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    if (clear) begin
      credits_d = CRW'(DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits_d = credits_q - CRW'(1);
        2'b01:   credits_d = credits_q + CRW'(1);
        default: credits_d = credits_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      credits_q <= CRW'(DEPTH);
      rdy_en_q  <= 1'b0;
      issue_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      rdy_en_q  <= 1'b1;
      issue_q   <= accept;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      pipe_q <= (pipe_q << 1) | LATENCY'(issue_q);
    end
  end

  adder_issuer_fifo #(
    .W     (C_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (capture),
    .push_data (add_c),
    .pop       (pop),
    .head      (res_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef ADDER_ISSUER_CHECK_EN
  logic [A_W-1:0] op_a_q [LATENCY];
  logic [A_W-1:0] op_b_q [LATENCY];
  logic           err_q;
  logic [7:0]     err_cnt_q;
  logic [C_W-1:0] exp_c;

  assign exp_c   = C_W'(op_a_q[LATENCY-1]) + C_W'(op_b_q[LATENCY-1]);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
      end
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      op_a_q[0] <= a_q;
      op_b_q[0] <= b_q;
      for (int i = 1; i < LATENCY; i++) begin
        op_a_q[i] <= op_a_q[i-1];
        op_b_q[i] <= op_b_q[i-1];
      end
      if (capture && (add_c != exp_c)) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end
`endif

  a_credit_range: assert property (@(posedge clk) disable iff (!reset)
    credits_q <= CRW'(DEPTH));
  a_credit_sum: assert property (@(posedge clk) disable iff (!reset)
    ($countones({issue_q, pipe_q}) + int'(credits_q) + int'(fifo_count)) == DEPTH);
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(capture && fifo_full && !pop));

endmodule

// File: tb/tb_adder_issuer.sv
// tb/tb_adder_issuer.sv - self-checking bench for adder_issuer (two configurations)
module tb_adder_issuer;

  localparam int A_W = 4;
  localparam int C_W = 7;
  localparam int L1 = 1, D1 = 4;
  localparam int L2 = 3, D2 = 2;

  typedef struct {
    logic [A_W-1:0] a;
    logic [A_W-1:0] b;
    logic [C_W-1:0] c;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic corrupt;

  logic           flush1, in_valid1, in_ready1, add_valid1, res_valid1, res_ready1, busy1;
  logic [A_W-1:0] in_a1, in_b1, add_a1, add_b1;
  logic [C_W-1:0] add_c1, res_c1;
  logic           flush2, in_valid2, in_ready2, add_valid2, res_valid2, res_ready2, busy2;
  logic [A_W-1:0] in_a2, in_b2, add_a2, add_b2;
  logic [C_W-1:0] add_c2, res_c2;
`ifdef ADDER_ISSUER_CHECK_EN
  logic       err1, err2;
  logic [7:0] err_cnt1, err_cnt2;
`endif

  adder_issuer #(.A_W(A_W), .C_W(C_W), .LATENCY(L1), .DEPTH(D1)) u_dut1 (
    .clk(clk), .reset(resetn), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .add_a(add_a1), .add_b(add_b1), .add_valid(add_valid1),
    .add_c(add_c1), .res_valid(res_valid1), .res_ready(res_ready1), .res_c(res_c1), .busy(busy1)
`ifdef ADDER_ISSUER_CHECK_EN
    , .err(err1), .err_cnt(err_cnt1)
`endif
  );

  adder_issuer #(.A_W(A_W), .C_W(C_W), .LATENCY(L2), .DEPTH(D2)) u_dut2 (
    .clk(clk), .reset(resetn), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .add_a(add_a2), .add_b(add_b2), .add_valid(add_valid2),
    .add_c(add_c2), .res_valid(res_valid2), .res_ready(res_ready2), .res_c(res_c2), .busy(busy2)
`ifdef ADDER_ISSUER_CHECK_EN
    , .err(err2), .err_cnt(err_cnt2)
`endif
  );

  // Adder models: sum registered, then delayed so it is valid LATENCY cycles after issue.
  logic [C_W-1:0] sum1_q [L1];
  logic [C_W-1:0] sum2_q [L2];
  always @(posedge clk) begin
    sum1_q[0] <= (corrupt && add_a1 == 4'd9 && add_b1 == 4'd1) ? 7'd11 : C_W'(add_a1) + C_W'(add_b1);
    for (int i = 1; i < L1; i++) sum1_q[i] <= sum1_q[i-1];
    sum2_q[0] <= C_W'(add_a2) + C_W'(add_b2);
    for (int i = 1; i < L2; i++) sum2_q[i] <= sum2_q[i-1];
  end
  assign add_c1 = sum1_q[L1-1];
  assign add_c2 = sum2_q[L2-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle1(input string tag);
    check({tag, "_in_ready"}, in_ready1, 0);
    check({tag, "_add_valid"}, add_valid1, 0);
    check({tag, "_add_a"}, add_a1, 0);
    check({tag, "_add_b"}, add_b1, 0);
    check({tag, "_res_valid"}, res_valid1, 0);
    check({tag, "_res_c"}, res_c1, 0);
    check({tag, "_busy"}, busy1, 0);
  endtask

  task automatic wait_res1(output int n);
    n = 0;
    while (!res_valid1 && n < 30) begin
      step();
      n++;
    end
  endtask

  // Reference model for dut2: results are the operand sums in acceptance order, and
  // the issuer must be ready exactly when fewer than DEPTH results are owed.
  logic [C_W-1:0] exp_q[$];
  int acc2 = 0, pop2 = 0;

  task automatic run2(input int ncyc, input bit rnd);
    for (int c = 0; c < ncyc; c++) begin
      in_valid2  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      res_ready2 = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_a2      = A_W'($urandom);
      in_b2      = A_W'($urandom);
      check("d2_in_ready", in_ready2, ((acc2 - pop2) < D2));
      if (res_valid2 && res_ready2) begin
        if (exp_q.size() == 0) check("d2_spurious_res", res_valid2, 0);
        else begin
          check("d2_res_c", res_c2, exp_q.pop_front());
          pop2++;
        end
      end
      if (in_valid2 && in_ready2) begin
        exp_q.push_back(C_W'(in_a2) + C_W'(in_b2));
        acc2++;
      end
      step();
    end
  endtask

  vec_t vecs[6];
  vec_t pairs[6];
  int n, acc, nv, rv;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd3, 4'd4, 7'd7};
    vecs[1] = '{4'd15, 4'd15, 7'd30};
    vecs[2] = '{4'd0, 4'd0, 7'd0};
    vecs[3] = '{4'd15, 4'd0, 7'd15};
    vecs[4] = '{4'd8, 4'd7, 7'd15};
    vecs[5] = '{4'd9, 4'd6, 7'd15};
    pairs[0] = '{4'd2, 4'd2, 7'd4};
    pairs[1] = '{4'd2, 4'd3, 7'd5};
    pairs[2] = '{4'd3, 4'd3, 7'd6};
    pairs[3] = '{4'd3, 4'd4, 7'd7};
    pairs[4] = '{4'd4, 4'd4, 7'd8};
    pairs[5] = '{4'd4, 4'd5, 7'd9};

    resetn = 1'b0; corrupt = 1'b0;
    flush1 = 0; in_valid1 = 0; in_a1 = 0; in_b1 = 0; res_ready1 = 0;
    flush2 = 0; in_valid2 = 0; in_a2 = 0; in_b2 = 0; res_ready2 = 0;
    step(); step();
    check_idle1("reset");
    resetn = 1'b1;
    step(); step();

    // Single ops from the table: issue strobe, LATENCY+2 latency, pass-through result.
    for (int k = 0; k < 6; k++) begin
      in_a1 = vecs[k].a; in_b1 = vecs[k].b; in_valid1 = 1'b1; res_ready1 = 1'b1;
      check("vec_ready", in_ready1, 1);
      step();
      in_valid1 = 1'b0;
      check("vec_add_valid", add_valid1, 1);
      check("vec_add_a", add_a1, vecs[k].a);
      check("vec_add_b", add_b1, vecs[k].b);
      wait_res1(n);
      check("vec_latency", n + 1, L1 + 2);
      check("vec_res_c", res_c1, vecs[k].c);
      step();
      check("vec_drained", res_valid1, 0);
      check("vec_busy", busy1, 0);
    end

    // Back-to-back with the result port stalled: credits cap acceptance at DEPTH.
    res_ready1 = 1'b0; acc = 0; nv = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid1 = (c < 6);
      in_a1 = pairs[acc].a; in_b1 = pairs[acc].b;
      nv += int'(add_valid1);
      if (in_valid1 && in_ready1) acc++;
      step();
    end
    in_valid1 = 1'b0;
    check("b2b_accepted", acc, D1);
    check("b2b_issued", nv, D1);
    check("b2b_not_ready", in_ready1, 0);
    check("b2b_no_issue", add_valid1, 0);
    res_ready1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_res1(n);
      check("b2b_res_c", res_c1, pairs[j].c);
      step();
    end
    check("b2b_empty", res_valid1, 0);
    check("b2b_ready_again", in_ready1, 1);

    // Flush with one result buffered and two ops in flight.
    res_ready1 = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      in_valid1 = 1'b1; in_a1 = A_W'(j); in_b1 = A_W'(j);
      step();
    end
    in_valid1 = 1'b0; flush1 = 1'b1;
    check("flush_buffered", res_valid1, 1);
    step();
    flush1 = 1'b0;
    n = 0;
    while (!in_ready1 && n < 20) begin
      check("flush_busy", busy1, 1);
      step();
      n++;
    end
    check("flush_blocked_cycles", n, 3);
    check("flush_res_cleared", res_valid1, 0);
    check("flush_idle", busy1, 0);
    in_valid1 = 1'b1; in_a1 = 4'd15; in_b1 = 4'd15; res_ready1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    wait_res1(n);
    check("flush_next_res", res_c1, 30);
    step();
    check("flush_next_empty", res_valid1, 0);

    // Reset mid-stream drops everything in flight.
    res_ready1 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid1 = 1'b1; in_a1 = 4'd5; in_b1 = A_W'(j);
      step();
    end
    in_valid1 = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_idle1("midrst");
    res_ready1 = 1'b1; rv = 0;
    for (int c = 0; c < 10; c++) begin
      rv += int'(res_valid1);
      step();
    end
    check("midrst_no_stale", rv, 0);
    check("midrst_ready", in_ready1, 1);

    // Second configuration: sustained valid/ready, then random traffic, then drain.
    run2(20, 1'b0);
    run2(300, 1'b1);
    in_valid2 = 1'b0; res_ready2 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (res_valid2) begin
        if (exp_q.size() == 0) check("d2_drain_spurious", res_valid2, 0);
        else begin
          check("d2_drain_res_c", res_c2, exp_q.pop_front());
          pop2++;
        end
      end
      step();
    end
    check("d2_no_drops", pop2, acc2);
    check("d2_idle", busy2, 0);

`ifdef ADDER_ISSUER_CHECK_EN
    corrupt = 1'b1; res_ready1 = 1'b1;
    check("chk_err_reset", err1, 0);
    in_valid1 = 1'b1; in_a1 = 4'd9; in_b1 = 4'd1;
    step();
    in_valid1 = 1'b0;
    wait_res1(n);
    check("chk_passthru", res_c1, 11);
    check("chk_err", err1, 1);
    check("chk_err_cnt", err_cnt1, 1);
    step();
    in_valid1 = 1'b1; in_a1 = 4'd3; in_b1 = 4'd4;
    step();
    in_valid1 = 1'b0;
    wait_res1(n);
    check("chk_good_res", res_c1, 7);
    step();
    check("chk_err_sticky", err1, 1);
    check("chk_err_cnt_hold", err_cnt1, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("chk_err_cleared", err1, 0);
    check("chk_err_cnt_cleared", err_cnt1, 0);
    corrupt = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
